pc_gen: RTL

Parametrised next-generation program counter for the RISC-V core.
- Holds the fetch address and selects the next PC from sequential increment, branch, jump or trap redirects, with a fixed priority.
- Adds stall, a fetch valid/ready handshake, debug halt/resume, and misaligned-target detection.
- Sits between the control/branch unit and the instruction memory; usable by both the single-cycle and pipelined cores.

---
 rtl/pc_gen_if.sv | 44 ++++
 rtl/pc_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: request/response bundle between the control/branch unit and the
// program-counter generator.
//   master : driven by the control side (stall, handshake, redirects, debug)
//   slave  : the pc_gen side (drives pc, pc_plus, fetch_valid, error report)
// Signals:
//   stall, fetch_ready              - hold / instruction-memory accept
//   branch_taken/branch_target      - conditional branch redirect
//   jump_valid/jump_target          - JAL/JALR redirect
//   trap_valid/trap_vector          - trap redirect
//   halt_req, resume                - debug halt control
//   pc, pc_plus, fetch_valid        - fetch request out
//   misalign_err, err_addr, halted  - status out
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            fetch_ready;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump_valid;
  logic [XLEN-1:0] jump_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            fetch_valid;
  logic            misalign_err;
  logic [XLEN-1:0] err_addr;
  logic            halted;

  modport master (
    output stall, fetch_ready, branch_taken, branch_target, jump_valid,
           jump_target, trap_valid, trap_vector, halt_req, resume,
    input  pc, pc_plus, fetch_valid, misalign_err, err_addr, halted
  );

  modport slave (
    input  stall, fetch_ready, branch_taken, branch_target, jump_valid,
           jump_target, trap_valid, trap_vector, halt_req, resume,
    output pc, pc_plus, fetch_valid, misalign_err, err_addr, halted
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter generator for the RISC-V core.
// Holds the fetch address and picks the next PC with fixed priority
// trap > jump > branch > sequential. Supports stall, a fetch valid/ready
// handshake, debug halt/resume and misaligned branch/jump target detection.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - pc_gen_if.slave (requests in; pc, pc_plus, fetch_valid,
//          misalign_err, err_addr, halted out)
module pc_gen #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR    = 32'h0000_0000,
  parameter logic [XLEN-1:0] MISALIGN_VECTOR = 32'h0000_0010,
  parameter int unsigned     INC             = 32'd4,
  parameter int unsigned     ALIGN_BITS      = 32'd2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] err_addr_r;
  logic            fetch_valid_r;
  logic            misalign_err_r;
  logic            halted_r;

  logic            redir_s;
  logic [XLEN-1:0] redir_pc_s;
  logic            mis_s;
  logic [XLEN-1:0] mis_addr_s;
  logic [XLEN-1:0] pc_plus_s;

  // True when any of the low ALIGN_BITS of an address are set.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  assign pc_plus_s = pc_r + XLEN'(INC);

  // Resolve the highest-priority redirect; misaligned jump/branch targets
  // are replaced by MISALIGN_VECTOR and reported instead of loaded.
  always_comb begin
    redir_s    = 1'b0;
    redir_pc_s = pc_r;
    mis_s      = 1'b0;
    mis_addr_s = ZERO;
    if (bus.trap_valid) begin
      redir_s    = 1'b1;
      redir_pc_s = bus.trap_vector & ~ALIGN_MASK;
    end else if (bus.jump_valid) begin
      redir_s = 1'b1;
      if (is_misaligned(bus.jump_target)) begin
        redir_pc_s = MISALIGN_VECTOR;
        mis_s      = 1'b1;
        mis_addr_s = bus.jump_target;
      end else begin
        redir_pc_s = bus.jump_target;
      end
    end else if (bus.branch_taken) begin
      redir_s = 1'b1;
      if (is_misaligned(bus.branch_target)) begin
        redir_pc_s = MISALIGN_VECTOR;
        mis_s      = 1'b1;
        mis_addr_s = bus.branch_target;
      end else begin
        redir_pc_s = bus.branch_target;
      end
    end else begin
      redir_s = 1'b0;
    end
  end

  // BOOT/RUN/HALT state machine with registered pc and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_BOOT;
      pc_r           <= RESET_VECTOR;
      err_addr_r     <= ZERO;
      fetch_valid_r  <= 1'b0;
      misalign_err_r <= 1'b0;
      halted_r       <= 1'b0;
    end else begin
      // misalign_err is a single-cycle pulse unless re-armed below.
      misalign_err_r <= 1'b0;
      case (state_r)
        ST_BOOT: begin
          // Requests are ignored while booting; pc stays at RESET_VECTOR.
          state_r       <= ST_RUN;
          fetch_valid_r <= 1'b1;
          halted_r      <= 1'b0;
        end
        ST_RUN: begin
          if (redir_s) begin
            pc_r <= redir_pc_s;
            if (mis_s) begin
              err_addr_r     <= mis_addr_s;
              misalign_err_r <= 1'b1;
            end
          end else if (!bus.halt_req && fetch_valid_r && bus.fetch_ready && !bus.stall) begin
            pc_r <= pc_plus_s;
          end
          if (bus.halt_req) begin
            state_r       <= ST_HALT;
            fetch_valid_r <= 1'b0;
            halted_r      <= 1'b1;
          end
        end
        ST_HALT: begin
          // Redirects still land while halted; sequential advance never does.
          if (redir_s) begin
            pc_r <= redir_pc_s;
            if (mis_s) begin
              err_addr_r     <= mis_addr_s;
              misalign_err_r <= 1'b1;
            end
          end
          // resume beats a simultaneous halt_req.
          if (bus.resume) begin
            state_r       <= ST_RUN;
            fetch_valid_r <= 1'b1;
            halted_r      <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_BOOT;
          pc_r          <= RESET_VECTOR;
          fetch_valid_r <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = pc_r;
  assign bus.pc_plus      = pc_plus_s;
  assign bus.fetch_valid  = fetch_valid_r;
  assign bus.misalign_err = misalign_err_r;
  assign bus.err_addr     = err_addr_r;
  assign bus.halted       = halted_r;

endmodule
